// File: rtl/mfp_ahb_lite_single_master_if.sv
// Bundle of AHB-Lite bus signals plus the command/response port of the single-master initiator.
// The master modport is the initiator's view; the slave modport is the bus/engine side.
interface mfp_ahb_lite_single_master_if;
   logic [31:0] HADDR;
   logic [2:0]  HBURST;
   logic        HMASTLOCK;
   logic [3:0]  HPROT;
   logic [2:0]  HSIZE;
   logic [1:0]  HTRANS;
   logic [31:0] HWDATA;
   logic        HWRITE;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic        HRESP;

   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        req_write;
   logic [2:0]  req_size;
   logic [31:0] req_wdata;

   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_timeout;

   modport master (
      output HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE,
      input  HRDATA, HREADY, HRESP,
      input  req_valid, req_addr, req_write, req_size, req_wdata,
      output req_ready,
      output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      input  rsp_ready
   );

   modport slave (
      input  HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE,
      output HRDATA, HREADY, HRESP,
      output req_valid, req_addr, req_write, req_size, req_wdata,
      input  req_ready,
      input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      output rsp_ready
   );
endinterface

// File: rtl/mfp_ahb_lite_single_master.sv
// AHB-Lite initiator: one non-burst transfer per accepted command, result returned on a
// held response port. Misaligned/illegal commands are answered with an error and never reach the bus.
module mfp_ahb_lite_single_master #(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter logic [3:0]  HPROT_VALUE    = 4'b0011
) (
   input  logic                                HCLK,
   input  logic                                HRESETn,
   mfp_ahb_lite_single_master_if.master        bus
);
   localparam int unsigned      CNT_W     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [1:0]       HTRANS_IDLE   = 2'b00;
   localparam logic [1:0]       HTRANS_NONSEQ = 2'b10;

   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} state_t;

   state_t            state_q, state_d;
   logic [31:0]       haddr_q, haddr_d;
   logic [2:0]        hsize_q, hsize_d;
   logic              hwrite_q, hwrite_d;
   logic [31:0]       hwdata_q, hwdata_d;
   logic [1:0]        htrans_q, htrans_d;
   logic              req_ready_q, req_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [31:0]       rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic              rsp_timeout_q, rsp_timeout_d;
   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;

   logic              accept;
   logic              req_illegal;
   logic [CNT_W-1:0]  wait_cnt_inc;
   logic              timeout_hit;

   assign accept       = bus.req_valid && req_ready_q;
   assign req_illegal  = (bus.req_size > 3'd2) ||
                         (bus.req_size == 3'd1 && bus.req_addr[0]) ||
                         (bus.req_size == 3'd2 && bus.req_addr[1:0] != 2'b00);
   // A wait cycle that would bring the count to the limit ends the transfer instead.
   assign wait_cnt_inc = wait_cnt_q + 1'b1;
   assign timeout_hit  = (TIMEOUT_CYCLES != 0) && (wait_cnt_inc == CNT_LIMIT);

   always_comb begin
      state_d       = state_q;
      haddr_d       = haddr_q;
      hsize_d       = hsize_q;
      hwrite_d      = hwrite_q;
      hwdata_d      = hwdata_q;
      htrans_d      = htrans_q;
      req_ready_d   = req_ready_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;
      wait_cnt_d    = wait_cnt_q;

      case (state_q)
         ST_IDLE: begin
            req_ready_d = 1'b1;
            if (accept) begin
               req_ready_d   = 1'b0;
               haddr_d       = bus.req_addr;
               hsize_d       = bus.req_size;
               hwrite_d      = bus.req_write;
               hwdata_d      = bus.req_wdata;
               rsp_rdata_d   = 32'h0;
               rsp_err_d     = 1'b0;
               rsp_timeout_d = 1'b0;
               wait_cnt_d    = '0;
               if (req_illegal) begin
                  state_d     = ST_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end else begin
                  state_d  = ST_ADDR;
                  htrans_d = HTRANS_NONSEQ;
               end
            end
         end
         ST_ADDR: begin
            if (bus.HREADY) begin
               state_d  = ST_DATA;
               htrans_d = HTRANS_IDLE;
            end else if (timeout_hit) begin
               state_d       = ST_RESP;
               htrans_d      = HTRANS_IDLE;
               rsp_valid_d   = 1'b1;
               rsp_timeout_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_inc;
            end
         end
         ST_DATA: begin
            if (bus.HREADY) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = bus.HRESP;
               rsp_rdata_d = (!hwrite_q && !bus.HRESP) ? bus.HRDATA : 32'h0;
            end else if (timeout_hit) begin
               state_d       = ST_RESP;
               rsp_valid_d   = 1'b1;
               rsp_timeout_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_inc;
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               state_d       = ST_IDLE;
               rsp_valid_d   = 1'b0;
               rsp_err_d     = 1'b0;
               rsp_timeout_d = 1'b0;
               req_ready_d   = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q       <= ST_IDLE;
         haddr_q       <= 32'h0;
         hsize_q       <= 3'h0;
         hwrite_q      <= 1'b0;
         hwdata_q      <= 32'h0;
         htrans_q      <= HTRANS_IDLE;
         req_ready_q   <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= 32'h0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         wait_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         haddr_q       <= haddr_d;
         hsize_q       <= hsize_d;
         hwrite_q      <= hwrite_d;
         hwdata_q      <= hwdata_d;
         htrans_q      <= htrans_d;
         req_ready_q   <= req_ready_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
         wait_cnt_q    <= wait_cnt_d;
      end
   end

   assign bus.HADDR       = haddr_q;
   assign bus.HBURST      = 3'b000;
   assign bus.HMASTLOCK   = 1'b0;
   assign bus.HPROT       = HPROT_VALUE;
   assign bus.HSIZE       = hsize_q;
   assign bus.HTRANS      = htrans_q;
   assign bus.HWDATA      = hwdata_q;
   assign bus.HWRITE      = hwrite_q;
   assign bus.req_ready   = req_ready_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_rdata   = rsp_rdata_q;
   assign bus.rsp_err     = rsp_err_q;
   assign bus.rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_mfp_ahb_lite_single_master.sv
// Randomized scoreboard bench: a scripted AHB slave answers each transfer, a transaction-level
// model predicts status/data/latency, and a monitor checks every response the initiator presents.
module tb_mfp_ahb_lite_single_master;
   localparam int T_OUT = 4;

   typedef struct {
      logic [31:0] addr;
      logic        write;
      logic [2:0]  size;
      logic [31:0] wdata;
      int          aw;
      int          dw;
      logic        err;
      logic [31:0] rdata;
   } txn_t;

   typedef struct {
      logic        err;
      logic        to;
      logic [31:0] rd;
      int          lat;
      int          acc;
   } exp_t;

   logic clk = 1'b0;
   logic HRESETn;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   txn_t plan_q[$];
   exp_t exp_q[$];

   mfp_ahb_lite_single_master_if bus();

   mfp_ahb_lite_single_master #(
      .TIMEOUT_CYCLES (T_OUT),
      .HPROT_VALUE    (4'b0011)
   ) dut (
      .HCLK    (clk),
      .HRESETn (HRESETn),
      .bus     (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic bit is_legal(input logic [31:0] addr, input logic [2:0] size);
      if (size > 3'd2) return 1'b0;
      return (addr % (32'd1 << size)) == 32'd0;
   endfunction

   // Outcome from the transfer rules: status, returned data, and edges from accept to rsp_valid.
   function automatic exp_t model(input txn_t t);
      exp_t e;
      int   waits;
      e.err = 1'b0; e.to = 1'b0; e.rd = 32'h0; e.lat = 0; e.acc = 0;
      if (!is_legal(t.addr, t.size)) begin
         e.err = 1'b1;
      end else begin
         waits = t.aw + t.dw + (t.err ? 1 : 0);
         if (waits >= T_OUT) begin
            e.to  = 1'b1;
            e.lat = (t.aw >= T_OUT) ? T_OUT : T_OUT + 1;
         end else begin
            e.err = t.err;
            e.rd  = (!t.write && !t.err) ? t.rdata : 32'h0;
            e.lat = 2 + waits;
         end
      end
      return e;
   endfunction

   // ---------------- scripted slave ----------------
   initial begin
      int   sph;
      int   aw;
      int   dw;
      bit   err_done;
      txn_t cur;
      sph = 0; aw = 0; dw = 0; err_done = 0;
      bus.HREADY = 1'b1;
      bus.HRESP  = 1'b0;
      bus.HRDATA = 32'h0;
      forever begin
         @(negedge clk);
         bus.HRDATA = $urandom;
         if (!HRESETn) begin
            sph = 0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
            plan_q.delete();
         end else if (bus.rsp_valid) begin
            sph = 0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
         end else begin
            if (sph == 0 && bus.HTRANS == 2'b10) begin
               if (plan_q.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL unexpected_nonseq: got HTRANS=%0d at 0x%08h want no transfer", bus.HTRANS, bus.HADDR);
               end else begin
                  cur = plan_q.pop_front();
                  aw  = cur.aw;
                  sph = 1;
               end
            end
            if (sph == 1) begin
               chk("addr_phase_htrans", 32'(bus.HTRANS), 32'h2);
               chk("addr_phase_haddr", bus.HADDR, cur.addr);
               chk("addr_phase_hsize", 32'(bus.HSIZE), 32'(cur.size));
               chk("addr_phase_hwrite", 32'(bus.HWRITE), 32'(cur.write));
               if (aw > 0) begin
                  bus.HREADY = 1'b0; aw--;
               end else begin
                  bus.HREADY = 1'b1; sph = 2; dw = cur.dw; err_done = 0;
               end
            end else if (sph == 2) begin
               chk("data_phase_htrans", 32'(bus.HTRANS), 32'h0);
               if (cur.write) chk("data_phase_hwdata", bus.HWDATA, cur.wdata);
               if (dw > 0) begin
                  bus.HREADY = 1'b0; bus.HRESP = 1'b0; dw--;
               end else if (cur.err && !err_done) begin
                  bus.HREADY = 1'b0; bus.HRESP = 1'b1; err_done = 1;
               end else begin
                  bus.HREADY = 1'b1; bus.HRESP = cur.err; bus.HRDATA = cur.rdata; sph = 3;
               end
            end else if (sph == 3) begin
               sph = 0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
            end
         end
      end
   end

   // ---------------- response monitor ----------------
   initial begin
      bit   pend;
      bit   clr;
      int   stall;
      exp_t e;
      pend = 0; clr = 0; stall = 0;
      bus.rsp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (clr) pend = 0;
         if (!HRESETn) pend = 0;
         if (HRESETn && bus.rsp_valid) begin
            if (!pend) begin
               if (exp_q.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL unexpected_rsp: got rsp_valid=1 want no response pending (cycle %0d)", cyc);
                  e.err = bus.rsp_err; e.to = bus.rsp_timeout; e.rd = bus.rsp_rdata;
               end else begin
                  e = exp_q.pop_front();
                  chk("rsp_latency", 32'(cyc - e.acc - 1), 32'(e.lat));
                  if ($urandom_range(0, 7) == 0) stall = 10;
               end
               pend = 1;
            end
            chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(e.to));
            chk("rsp_rdata", bus.rsp_rdata, e.rd);
            chk("req_ready_in_resp", 32'(bus.req_ready), 32'h0);
         end
         if (stall > 0) begin
            bus.rsp_ready = 1'b0; stall--;
         end else begin
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
         end
         clr = bus.rsp_valid && bus.rsp_ready;
      end
   end

   // ---------------- stimulus ----------------
   task automatic do_txn(input txn_t t, input bit want_rsp, output bit accepted);
      bit   rdy;
      int   k;
      exp_t e;
      if (is_legal(t.addr, t.size)) plan_q.push_back(t);
      bus.req_addr  = t.addr;
      bus.req_write = t.write;
      bus.req_size  = t.size;
      bus.req_wdata = t.wdata;
      bus.req_valid = 1'b1;
      accepted = 0;
      k = 0;
      forever begin
         rdy = bus.req_ready;
         @(posedge clk);
         if (rdy) begin
            accepted = 1;
            e = model(t);
            e.acc = cyc;
            if (want_rsp) exp_q.push_back(e);
            $display("txn addr=0x%08h wr=%0d size=%0d aw=%0d dw=%0d err=%0d -> exp err=%0d to=%0d rd=0x%08h lat=%0d",
                     t.addr, t.write, t.size, t.aw, t.dw, t.err, e.err, e.to, e.rd, e.lat);
            break;
         end
         @(negedge clk);
         k++;
         if (k > 300) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: got no accept want accept within 300 cycles");
            break;
         end
      end
      @(negedge clk);
   endtask

   function automatic txn_t mk(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                               input logic [31:0] wdata, input int aw, input int dw,
                               input logic err, input logic [31:0] rdata);
      txn_t t;
      t.addr = addr; t.write = wr; t.size = size; t.wdata = wdata;
      t.aw = aw; t.dw = dw; t.err = err; t.rdata = rdata;
      return t;
   endfunction

   function automatic txn_t rnd_txn();
      txn_t t;
      int   r;
      r = $urandom_range(0, 9);
      t.size  = (r < 2) ? 3'd0 : (r < 4) ? 3'd1 : (r < 9) ? 3'd2 : 3'($urandom_range(3, 7));
      t.addr  = $urandom;
      if (t.size <= 3'd2 && $urandom_range(0, 3) != 0) t.addr = t.addr & ~((32'd1 << t.size) - 32'd1);
      t.write = 1'($urandom_range(0, 1));
      t.wdata = $urandom;
      t.aw    = $urandom_range(0, 2);
      t.dw    = $urandom_range(0, 2);
      t.err   = ($urandom_range(0, 5) == 0);
      t.rdata = $urandom;
      return t;
   endfunction

   initial begin
      txn_t dir[7];
      txn_t t;
      bit   acc;
      int   k;
      HRESETn       = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_addr  = 32'h0;
      bus.req_write = 1'b0;
      bus.req_size  = 3'h0;
      bus.req_wdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_htrans", 32'(bus.HTRANS), 32'h0);
      chk("reset_haddr", bus.HADDR, 32'h0);
      chk("reset_hwdata", bus.HWDATA, 32'h0);
      chk("reset_req_ready", 32'(bus.req_ready), 32'h0);
      chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      chk("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
      @(negedge clk);
      HRESETn = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_req_ready", 32'(bus.req_ready), 32'h1);
      chk("const_hburst", 32'(bus.HBURST), 32'h0);
      chk("const_hmastlock", 32'(bus.HMASTLOCK), 32'h0);
      chk("const_hprot", 32'(bus.HPROT), 32'h3);
      @(negedge clk);

      dir[0] = mk(32'h1F80_0000, 1'b1, 3'd2, 32'hDEAD_BEEF, 0, 0, 1'b0, 32'h0);
      dir[1] = mk(32'h1F80_0008, 1'b0, 3'd2, 32'h0, 0, 3, 1'b0, 32'h0000_00A5);
      dir[2] = mk(32'h1F80_0001, 1'b0, 3'd1, 32'h0, 0, 0, 1'b0, 32'h1234_5678);
      dir[3] = mk(32'h1F80_0004, 1'b1, 3'd3, 32'h5555_AAAA, 0, 0, 1'b0, 32'h0);
      dir[4] = mk(32'h1F80_0010, 1'b0, 3'd2, 32'h0, 0, 0, 1'b1, 32'hCAFE_F00D);
      dir[5] = mk(32'h1F80_0014, 1'b0, 3'd2, 32'h0, 0, 10, 1'b0, 32'h7777_7777);
      dir[6] = mk(32'h1F80_0018, 1'b1, 3'd0, 32'h0000_00EE, 6, 0, 1'b0, 32'h0);
      foreach (dir[i]) do_txn(dir[i], 1'b1, acc);

      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            bus.req_valid = 1'b0;
            repeat ($urandom_range(1, 4)) @(negedge clk);
         end
         t = rnd_txn();
         do_txn(t, 1'b1, acc);
      end
      bus.req_valid = 1'b0;

      k = 0;
      while ((exp_q.size() != 0 || bus.rsp_valid) && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk("drain_before_reset", 32'(exp_q.size()), 32'h0);

      // Reset while the address phase is being held by wait states.
      t = mk(32'h1F80_0020, 1'b0, 3'd2, 32'h0, 3, 0, 1'b0, 32'hBAD0_BAD0);
      do_txn(t, 1'b0, acc);
      bus.req_valid = 1'b0;
      chk("pre_reset_htrans_nonseq", 32'(bus.HTRANS), 32'h2);
      #1;
      HRESETn = 1'b0;
      #1;
      chk("async_reset_htrans", 32'(bus.HTRANS), 32'h0);
      chk("async_reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      chk("async_reset_haddr", bus.HADDR, 32'h0);
      @(negedge clk);
      HRESETn = 1'b1;
      repeat (2) @(negedge clk);

      t = mk(32'h1F80_0024, 1'b0, 3'd1, 32'h0, 1, 1, 1'b0, 32'h0000_BEEF);
      do_txn(t, 1'b1, acc);
      bus.req_valid = 1'b0;
      k = 0;
      while ((exp_q.size() != 0 || bus.rsp_valid) && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("final_drain", 32'(exp_q.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
